// File: rtl/divisor_pkg.sv
// Shared types and the single restoring-division step used by divisor_seq.
package divisor_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 16;

    typedef struct packed {
        logic                 q_bit;
        logic [MAX_WIDTH:0]   rem;
    } step_t;

    // Operands are zero-extended to MAX_WIDTH+1 so one function serves every legal WIDTH.
    function automatic step_t sub_or_keep(input logic [MAX_WIDTH:0] rem,
                                          input logic [MAX_WIDTH:0] b);
        step_t s;
        if (rem >= b) begin
            s.q_bit = 1'b1;
            s.rem   = rem - b;
        end else begin
            s.q_bit = 1'b0;
            s.rem   = rem;
        end
        return s;
    endfunction

endpackage

// File: rtl/divisor_passo.sv
// One restoring step: shift in the next dividend bit, compare against B, subtract or keep.
module divisor_passo
    import divisor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [MAX_WIDTH:0] rem_ext;
    logic [MAX_WIDTH:0] b_ext;
    step_t              s;
    logic               unused_bits;

    // NOTE: every variable written here gets a default first, so no path leaves a latch.
    always_comb begin
        rem_ext            = '0;
        b_ext              = '0;
        rem_ext[WIDTH:0]   = {rem[WIDTH-1:0], dvd_msb};
        b_ext[WIDTH-1:0]   = b;
        s                  = sub_or_keep(rem_ext, b_ext);
        rem_out            = s.rem[WIDTH:0];
        q_bit              = s.q_bit;
    end

    // rem[WIDTH] is always 0 after a restoring step, so the shift drops it.
    assign unused_bits = ^{rem[WIDTH], s};

endmodule

// File: rtl/divisor_seq.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
module divisor_seq
    import divisor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [CW-1:0]    cnt;

    divisor_passo #(.WIDTH(WIDTH)) u_passo (
        .rem     (rem),
        .dvd_msb (dvd[WIDTH-1]),
        .b       (divisor),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (B == '0) ? DONE : CALC;
            CALC: if (cnt == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Quotient bits shift into the low end of dvd as dividend bits leave the top.
    // NOTE: every datapath register is reset so an aborted division leaves no stale result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd      <= '0;
            divisor  <= '0;
            rem      <= '0;
            cnt      <= '0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd     <= A;
                        divisor <= B;
                        rem     <= '0;
                        cnt     <= CW'(WIDTH - 1);
                        if (B == '0) begin
                            Q        <= '1;
                            R        <= A;
                            div_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    dvd <= {dvd[WIDTH-2:0], step_q};
                    if (cnt == '0) begin
                        Q        <= {dvd[WIDTH-2:0], step_q};
                        R        <= step_rem[WIDTH-1:0];
                        div_zero <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_divisor_seq.sv
// Scoreboard bench for divisor_seq: accepted requests queue expected results, a monitor checks each done.
module tb_divisor_seq;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic [W-1:0] q, r;
    logic         busy, done, div_zero;

    always #5 clk = ~clk;

    divisor_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (a_in),
        .B        (b_in),
        .Q        (q),
        .R        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    typedef struct {
        int a, b, q, r, dz, acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0, fails = 0, cyc = 0, accept_cnt = 0;
    int   last_q = 0, last_r = 0, last_dz = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division; divide-by-zero yields all ones and R = A.
    function automatic exp_t model(input int a, input int b, input int acc);
        exp_t e;
        e.a = a; e.b = b; e.acc = acc;
        if (b == 0) begin
            e.q = (1 << W) - 1; e.r = a; e.dz = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 0;
        end
        return e;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // A request is taken at the next edge when start is high while idle.
    always @(negedge clk) begin
        if (rst_n && start && !busy) begin
            sb.push_back(model(int'(a_in), int'(b_in), cyc + 1));
            accept_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1, expected no pending request (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("Q %0d/%0d", mon_e.a, mon_e.b), int'(q), mon_e.q);
                    check($sformatf("R %0d/%0d", mon_e.a, mon_e.b), int'(r), mon_e.r);
                    check($sformatf("div_zero %0d/%0d", mon_e.a, mon_e.b), int'(div_zero), mon_e.dz);
                    check($sformatf("latency %0d/%0d", mon_e.a, mon_e.b), cyc - mon_e.acc,
                          (mon_e.b == 0) ? 0 : W);
                    if (mon_e.b != 0)
                        check($sformatf("invariant %0d/%0d", mon_e.a, mon_e.b),
                              ((int'(q) * mon_e.b + int'(r) == mon_e.a) && (int'(r) < mon_e.b)) ? 1 : 0, 1);
                    last_q = mon_e.q; last_r = mon_e.r; last_dz = mon_e.dz;
                end
            end else begin
                check("hold Q", int'(q), last_q);
                check("hold R", int'(r), last_r);
                check("hold div_zero", int'(div_zero), last_dz);
            end
        end
    end

    always @(negedge rst_n) begin
        sb.delete();
        last_q = 0; last_r = 0; last_dz = 0;
    end

    task automatic wait_accepts(input int target);
        int n;
        n = 0;
        while (accept_cnt < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (accept_cnt < target) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got %0d accepts, expected %0d", accept_cnt, target);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n     = accept_cnt;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        wait_accepts(n + 1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                @(posedge clk); #1;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL idle_timeout: got busy=%0b pending=%0d, expected idle and empty", busy, sb.size());
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("reset Q", int'(q), 0);
        check("reset R", int'(r), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset div_zero", int'(div_zero), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(4'd13, 4'd3);
        @(negedge clk);
        check("busy after accept", int'(busy), 1);
        check("done after accept", int'(done), 0);
        wait_idle();

        issue(4'd15, 4'd1);
        issue(4'd2, 4'd5);
        wait_idle();

        issue(4'd9, 4'd0);
        issue(4'd8, 4'd2);
        wait_idle();

        // A second request while busy must be dropped, not queued.
        issue(4'd7, 4'd2);
        a_in = 4'd14; b_in = 4'd7; start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // start held high re-triggers on the first idle edge with the new operands.
        n = accept_cnt;
        a_in = 4'd6; b_in = 4'd4; start = 1'b1;
        wait_accepts(n + 1);
        a_in = 4'd10; b_in = 4'd3;
        wait_accepts(n + 2);
        start = 1'b0;
        wait_idle();

        issue(4'd12, 4'd5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort Q", int'(q), 0);
        check("abort R", int'(r), 0);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort div_zero", int'(div_zero), 0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'd12, 4'd5);
        wait_idle();

        for (int a = 0; a < (1 << W); a++)
            for (int b = 0; b < (1 << W); b++)
                issue(W'(a), W'(b));
        wait_idle();

        for (int i = 0; i < 40; i++)
            issue(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
        wait_idle();

        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
